resp_router: RTL and testbench

Return-path router for the streaming crossbar. It takes response streams from M_DATA_COUNT master-side sources, steers each beat back to the slave-side sink named by the beat's id field, and keeps each packet intact. Where several sources target one sink, a per-sink round-robin arbiter with packet lock picks one source at a time. Each sink has a registered output stage. The block is the reverse-direction counterpart of the forward scheduler: forward traffic is routed by dest, responses are routed by id.

---
 rtl/resp_router.sv | 226 ++++++++++++++++++++++
 tb/tb_resp_router.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/resp_router.sv
// resp_router: return-path router that steers response beats to the sink named by their id,
// with per-sink round-robin packet-locked arbitration. Define RESP_ROUTER_SKID_EN for 2-entry skid sink FIFOs.
module resp_router #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 3,
    parameter int M_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
    parameter int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_i,
    input  logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_i,
    input  logic [M_DATA_COUNT-1:0]              m_last_i,
    input  logic [M_DATA_COUNT-1:0]              m_valid_i,
    output logic [M_DATA_COUNT-1:0]              m_ready_o,
    output logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_o,
    output logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_src_o,
    output logic [S_DATA_COUNT-1:0]              s_last_o,
    output logic [S_DATA_COUNT-1:0]              s_valid_o,
    input  logic [S_DATA_COUNT-1:0]              s_ready_i,
    output logic                                 err_o
);

    // Handshake: a beat moves on any edge where valid and ready are both high; valid never
    // waits on ready, and a source with an out-of-range id is always ready (beat dropped).

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    typedef struct packed {
        state_e                  state;
        logic [T_DEST_WIDTH-1:0] owner;
        logic [T_DEST_WIDTH-1:0] ptr;
    } arb_t;

    arb_t [S_DATA_COUNT-1:0] arb_q;

    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0] req;
    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0] grant;
    logic [M_DATA_COUNT-1:0]                   bad_id;
    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] sel_src;
    logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] sel_data;
    logic [S_DATA_COUNT-1:0]                   sel_last;
    logic [S_DATA_COUNT-1:0]                   stage_rdy;
    logic [S_DATA_COUNT-1:0]                   load;

    logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] data_q;
    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] src_q;
    logic [S_DATA_COUNT-1:0]                   last_q;
    logic [S_DATA_COUNT-1:0]                   valid_q;
    logic                                      err_q;

    always_comb begin
        for (int k = 0; k < M_DATA_COUNT; k++) begin
            bad_id[k] = int'(m_id_i[k*T_ID___WIDTH +: T_ID___WIDTH]) >= S_DATA_COUNT;
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                req[j][k] = m_valid_i[k] &&
                            (int'(m_id_i[k*T_ID___WIDTH +: T_ID___WIDTH]) == j);
            end
        end
    end

    // IDLE searches from ptr+1 upward with wrap; LOCKED only ever matches the owner.
    always_comb begin
        logic found;
        found    = 1'b0;
        grant    = '0;
        sel_src  = '0;
        sel_data = '0;
        sel_last = '0;
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            found = 1'b0;
            for (int off = 1; off <= M_DATA_COUNT; off++) begin
                for (int k = 0; k < M_DATA_COUNT; k++) begin
                    if (!found && req[j][k] &&
                        ((arb_q[j].state == LOCKED) ?
                            (k == int'(arb_q[j].owner)) :
                            (k == (int'(arb_q[j].ptr) + off) % M_DATA_COUNT))) begin
                        found       = 1'b1;
                        grant[j][k] = 1'b1;
                        sel_src[j]  = T_DEST_WIDTH'(k);
                        sel_data[j] = m_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
                        sel_last[j] = m_last_i[k];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            load[j] = (|grant[j]) && stage_rdy[j] && !rst;
        end
    end

    always_comb begin
        m_ready_o = '0;
        for (int k = 0; k < M_DATA_COUNT; k++) begin
            m_ready_o[k] = bad_id[k];
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (grant[j][k] && stage_rdy[j]) begin
                    m_ready_o[k] = 1'b1;
                end
            end
            if (rst) begin
                m_ready_o[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                arb_q[j].state <= IDLE;
                arb_q[j].owner <= '0;
                arb_q[j].ptr   <= T_DEST_WIDTH'(M_DATA_COUNT - 1);
            end
        end else begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (load[j]) begin
                    if (arb_q[j].state == IDLE) begin
                        if (sel_last[j]) begin
                            arb_q[j].ptr <= sel_src[j];
                        end else begin
                            arb_q[j].state <= LOCKED;
                            arb_q[j].owner <= sel_src[j];
                        end
                    end else if (sel_last[j]) begin
                        arb_q[j].state <= IDLE;
                        arb_q[j].ptr   <= arb_q[j].owner;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= |(m_valid_i & bad_id);
        end
    end

`ifdef RESP_ROUTER_SKID_EN
    // The head registers drive the sink; the skid entry absorbs one beat accepted while
    // the sink stalls, so ready can come from a register.
    logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] skd_data_q;
    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] skd_src_q;
    logic [S_DATA_COUNT-1:0]                   skd_last_q;
    logic [S_DATA_COUNT-1:0]                   full_q;

    assign stage_rdy = ~full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            src_q      <= '0;
            last_q     <= '0;
            valid_q    <= '0;
            skd_data_q <= '0;
            skd_src_q  <= '0;
            skd_last_q <= '0;
            full_q     <= '0;
        end else begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (full_q[j]) begin
                    if (s_ready_i[j]) begin
                        data_q[j] <= skd_data_q[j];
                        src_q[j]  <= skd_src_q[j];
                        last_q[j] <= skd_last_q[j];
                        full_q[j] <= 1'b0;
                    end
                end else if (valid_q[j]) begin
                    if (load[j] && s_ready_i[j]) begin
                        data_q[j] <= sel_data[j];
                        src_q[j]  <= sel_src[j];
                        last_q[j] <= sel_last[j];
                    end else if (load[j]) begin
                        skd_data_q[j] <= sel_data[j];
                        skd_src_q[j]  <= sel_src[j];
                        skd_last_q[j] <= sel_last[j];
                        full_q[j]     <= 1'b1;
                    end else if (s_ready_i[j]) begin
                        valid_q[j] <= 1'b0;
                    end
                end else if (load[j]) begin
                    data_q[j]  <= sel_data[j];
                    src_q[j]   <= sel_src[j];
                    last_q[j]  <= sel_last[j];
                    valid_q[j] <= 1'b1;
                end
            end
        end
    end
`else
    assign stage_rdy = ~valid_q | s_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            src_q   <= '0;
            last_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (load[j]) begin
                    data_q[j]  <= sel_data[j];
                    src_q[j]   <= sel_src[j];
                    last_q[j]  <= sel_last[j];
                    valid_q[j] <= 1'b1;
                end else if (s_ready_i[j]) begin
                    valid_q[j] <= 1'b0;
                end
            end
        end
    end
`endif

    assign s_data_o  = data_q;
    assign s_src_o   = src_q;
    assign s_last_o  = last_q;
    assign s_valid_o = valid_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_resp_router.sv
// Directed bench for resp_router: routing, packet lock, round-robin, backpressure, bad id, reset.
module tb_resp_router;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int M  = 3;
    localparam int IW = 2;
    localparam int DW = 2;
`ifdef RESP_ROUTER_SKID_EN
    localparam logic [8:0] BP_RDY = 9'b110000011;
`else
    localparam logic [8:0] BP_RDY = 9'b111000001;
`endif

    logic           clk;
    logic           rst;
    logic [W*M-1:0] m_data;
    logic [IW*M-1:0] m_id;
    logic [M-1:0]   m_last;
    logic [M-1:0]   m_valid;
    logic [M-1:0]   m_ready;
    logic [W*S-1:0] s_data;
    logic [DW*S-1:0] s_src;
    logic [S-1:0]   s_last;
    logic [S-1:0]   s_valid;
    logic [S-1:0]   s_ready;
    logic           err;

    logic [10:0] exp_q[$];
    logic [8:0]  bp_rdy;
    int          n_checks;
    int          n_pass;
    int          b;

    resp_router #(
        .T_DATA_WIDTH(W),
        .S_DATA_COUNT(S),
        .M_DATA_COUNT(M)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_data_i (m_data),
        .m_id_i   (m_id),
        .m_last_i (m_last),
        .m_valid_i(m_valid),
        .m_ready_o(m_ready),
        .s_data_o (s_data),
        .s_src_o  (s_src),
        .s_last_o (s_last),
        .s_valid_o(s_valid),
        .s_ready_i(s_ready),
        .err_o    (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic set_src(input int k, input logic v, input logic [1:0] id,
                           input logic [7:0] d, input logic l);
        m_valid[k]         = v;
        m_id[k*IW +: IW]   = id;
        m_data[k*W +: W]   = d;
        m_last[k]          = l;
    endtask

    task automatic clr_src();
        m_valid = '0;
        m_id    = '0;
        m_data  = '0;
        m_last  = '0;
    endtask

    // One cycle: check ready, let the sink consume against the scoreboard, record
    // beats the bench expects accepted, then advance past the edge.
    task automatic step(input int j, input logic [2:0] exp_rdy, input int exp_sv);
        logic [10:0] got;
        #1;
        check("m_ready", 32'(m_ready), 32'(exp_rdy));
        if (exp_sv >= 0) check("s_valid", 32'(s_valid[j]), exp_sv);
        if (s_valid[j] && s_ready[j]) begin
            got = {s_src[j*DW +: DW], s_last[j], s_data[j*W +: W]};
            if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
            else check("sink_beat", 32'(got), 32'(exp_q.pop_front()));
        end
        for (int k = 0; k < M; k++) begin
            if (exp_rdy[k] && m_valid[k] && int'(m_id[k*IW +: IW]) < S) begin
                exp_q.push_back({2'(k), m_last[k], m_data[k*W +: W]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bp_rdy   = BP_RDY;
        rst      = 1'b1;
        s_ready  = 3'b111;
        clr_src();
        for (int k = 0; k < M; k++) set_src(k, 1'b1, 2'd0, 8'h55, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_ready", 32'(m_ready), 0);
        check("rst_s_valid", 32'(s_valid), 0);
        check("rst_s_data", s_data, 0);
        check("rst_s_src", 32'(s_src), 0);
        check("rst_s_last", 32'(s_last), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        clr_src();

        // single-beat route: source 1 -> sink 2
        set_src(1, 1'b1, 2'd2, 8'hA5, 1'b1);
        step(2, 3'b010, 0);
        check("route_s_valid", 32'(s_valid), 32'(3'b100));
        check("route_s_data", 32'(s_data[2*W +: W]), 32'h A5);
        check("route_s_src", 32'(s_src[2*DW +: DW]), 1);
        clr_src();
        step(2, 3'b000, 1);
        check("route_drain", 32'(s_valid), 0);

        // round-robin on sink 0 with single-beat packets
        for (int k = 0; k < M; k++) set_src(k, 1'b1, 2'd0, 8'(16 + k), 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(0, 3'(1 << (i % 3)), (i == 0) ? 0 : 1);
            check("rr_src", 32'(s_src[1:0]), i % 3);
        end
        clr_src();
        step(0, 3'b000, 1);
        step(0, 3'b000, 0);
        check("rr_sb_empty", exp_q.size(), 0);

        // packet lock: source 0 4-beat packet to sink 1, source 2 joins from beat 2
        set_src(0, 1'b1, 2'd1, 8'h40, 1'b0);
        step(1, 3'b001, 0);
        set_src(0, 1'b1, 2'd1, 8'h41, 1'b0);
        set_src(2, 1'b1, 2'd1, 8'h60, 1'b0);
        step(1, 3'b001, 1);
        set_src(0, 1'b1, 2'd1, 8'h42, 1'b0);
        step(1, 3'b001, 1);
        set_src(0, 1'b1, 2'd1, 8'h43, 1'b1);
        step(1, 3'b001, 1);
        set_src(0, 1'b0, 2'd0, 8'h00, 1'b0);
        step(1, 3'b100, 1);
        set_src(2, 1'b1, 2'd1, 8'h61, 1'b1);
        step(1, 3'b100, 1);
        clr_src();
        step(1, 3'b000, 1);
        step(1, 3'b000, 0);
        check("lock_sb_empty", exp_q.size(), 0);

        // backpressure on sink 0 mid-packet, 5 stalled cycles
        b = 0;
        for (int c = 0; c < 9; c++) begin
            s_ready[0] = !(c >= 1 && c <= 5);
            if (b < 4) set_src(0, 1'b1, 2'd0, 8'(8'h80 + b), b == 3);
            else set_src(0, 1'b0, 2'd0, 8'h00, 1'b0);
            step(0, {2'b00, bp_rdy[c]}, (c == 0) ? 0 : 1);
            if (bp_rdy[c]) b++;
            if (c >= 1 && c <= 5) check("bp_hold", 32'(s_data[7:0]), 32'h80);
        end
        check("bp_beats", b, 4);
        clr_src();
        step(0, 3'b000, 1);
        step(0, 3'b000, 0);
        check("bp_sb_empty", exp_q.size(), 0);

        // out-of-range id from two sources at once
        set_src(1, 1'b1, 2'd3, 8'hEE, 1'b1);
        set_src(2, 1'b1, 2'd3, 8'hEF, 1'b1);
        step(0, 3'b110, 0);
        check("bad_err", 32'(err), 1);
        check("bad_no_sink", 32'(s_valid), 0);
        clr_src();
        step(0, 3'b000, 0);
        check("bad_err_once", 32'(err), 0);
        check("bad_still_empty", 32'(s_valid), 0);

        // reset mid-packet: source 2 locks sink 0, then rst
        set_src(2, 1'b1, 2'd0, 8'hC0, 1'b0);
        step(0, 3'b100, 0);
        set_src(2, 1'b1, 2'd0, 8'hC1, 1'b0);
        step(0, 3'b100, 1);
        rst        = 1'b1;
        s_ready[0] = 1'b0;
        set_src(0, 1'b1, 2'd0, 8'h10, 1'b1);
        step(0, 3'b000, 1);
        check("rst_mid_valid", 32'(s_valid), 0);
        check("rst_mid_data", 32'(s_data[7:0]), 0);
        exp_q.delete();
        rst        = 1'b0;
        s_ready[0] = 1'b1;
        for (int k = 0; k < M; k++) set_src(k, 1'b1, 2'd0, 8'(16 + k), 1'b1);
        step(0, 3'b001, 0);
        check("rst_prio_src", 32'(s_src[1:0]), 0);
        clr_src();
        step(0, 3'b000, 1);
        step(0, 3'b000, 0);
        check("rst_sb_empty", exp_q.size(), 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
